// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit: AND, OR and NOT(a) of two operand vectors in parallel, plus
// one op-selected result (AND/OR/NOT/XOR). One-cycle registered output stage with a valid strobe.

// Bitwise AND of two WIDTH-bit vectors.
module and_gate #(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = a & b;

endmodule

// Bitwise OR of two WIDTH-bit vectors.
module or_gate #(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   assign y = a | b;

endmodule

// Bitwise inversion of a WIDTH-bit vector.
module not_gate #(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);

   assign y = ~a;

endmodule

// Wrapper: combinational gate core followed by a single register stage.
module logic_gate_unit #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             in_valid,
   output logic [WIDTH-1:0] y_and,
   output logic [WIDTH-1:0] y_or,
   output logic [WIDTH-1:0] y_not,
   output logic [WIDTH-1:0] y_sel,
   output logic             out_valid
);

   typedef enum logic [1:0] {
      OpAnd = 2'b00,
      OpOr  = 2'b01,
      OpNot = 2'b10,
      OpXor = 2'b11
   } op_e;

   logic [WIDTH-1:0] and_res;
   logic [WIDTH-1:0] or_res;
   logic [WIDTH-1:0] not_res;
   logic [WIDTH-1:0] xor_res;
   logic [WIDTH-1:0] sel_res;

   and_gate #(
      .WIDTH (WIDTH)
   ) u_and (
      .a (a),
      .b (b),
      .y (and_res)
   );

   or_gate #(
      .WIDTH (WIDTH)
   ) u_or (
      .a (a),
      .b (b),
      .y (or_res)
   );

   not_gate #(
      .WIDTH (WIDTH)
   ) u_not (
      .a (a),
      .y (not_res)
   );

   // XOR has no dedicated gate block; derive it here.
   assign xor_res = a ^ b;

   // Pick the op-selected result from the parallel gate outputs.
   always_comb begin
      sel_res = '0;
      unique case (op_e'(op))
         OpAnd:   sel_res = and_res;
         OpOr:    sel_res = or_res;
         OpNot:   sel_res = not_res;
         OpXor:   sel_res = xor_res;
         default: sel_res = '0;
      endcase
   end

   // Result registers load only on accepted inputs so idle-cycle X/Z never reaches state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_and <= '0;
         y_or  <= '0;
         y_not <= '0;
         y_sel <= '0;
      end else if (in_valid) begin
         y_and <= and_res;
         y_or  <= or_res;
         y_not <= not_res;
         y_sel <= sel_res;
      end
   end

   // Valid strobe: one cycle high per accepted input; async reset cuts a pending pulse short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
      end
   end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit at WIDTH=1, 8 and 16.
module tb_logic_gate_unit;

   logic clk;
   logic rst;

   logic [0:0]  a1, b1, y1_and, y1_or, y1_not, y1_sel;
   logic [1:0]  op1;
   logic        iv1, ov1;

   logic [7:0]  a8, b8, y8_and, y8_or, y8_not, y8_sel;
   logic [1:0]  op8;
   logic        iv8, ov8;

   logic [15:0] a16, b16, y16_and, y16_or, y16_not, y16_sel;
   logic [1:0]  op16;
   logic        iv16, ov16;

   int checks = 0;
   int errors = 0;

   logic_gate_unit #(.WIDTH(1)) u_w1 (
      .clk (clk), .rst (rst), .a (a1), .b (b1), .op (op1), .in_valid (iv1),
      .y_and (y1_and), .y_or (y1_or), .y_not (y1_not), .y_sel (y1_sel), .out_valid (ov1)
   );

   logic_gate_unit #(.WIDTH(8)) u_w8 (
      .clk (clk), .rst (rst), .a (a8), .b (b8), .op (op8), .in_valid (iv8),
      .y_and (y8_and), .y_or (y8_or), .y_not (y8_not), .y_sel (y8_sel), .out_valid (ov8)
   );

   logic_gate_unit #(.WIDTH(16)) u_w16 (
      .clk (clk), .rst (rst), .a (a16), .b (b16), .op (op16), .in_valid (iv16),
      .y_and (y16_and), .y_or (y16_or), .y_not (y16_not), .y_sel (y16_sel), .out_valid (ov16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_w8(input string tag, input logic [7:0] ea, input logic [7:0] eo,
                           input logic [7:0] en, input logic [7:0] es, input logic ev);
      check({tag, ".y_and"}, 16'(y8_and), 16'(ea));
      check({tag, ".y_or"}, 16'(y8_or), 16'(eo));
      check({tag, ".y_not"}, 16'(y8_not), 16'(en));
      check({tag, ".y_sel"}, 16'(y8_sel), 16'(es));
      check({tag, ".out_valid"}, 16'(ov8), 16'(ev));
   endtask

   // Truth-table rows and op-select expectations
   logic [1:0] tt_ab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
   logic       tt_and [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic       tt_or  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
   logic       tt_not [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   logic [7:0] os_exp [4] = '{8'h00, 8'hFF, 8'h3A, 8'hFF};

   // Reference model state for the randomised phase
   logic [15:0] m_and, m_or, m_not, m_sel;
   logic        m_valid;
   logic [15:0] m_res [4];

   initial begin
      rst = 1'b1;
      a1 = '0; b1 = '0; op1 = '0; iv1 = 1'b0;
      a8 = '0; b8 = '0; op8 = '0; iv8 = 1'b0;
      a16 = '0; b16 = '0; op16 = '0; iv16 = 1'b0;

      // Reset state, with in_valid high on the 1-bit unit to show it is ignored
      iv1 = 1'b1; a1 = 1'b1;
      tick();
      tick();
      check("rst.w1.y_not", 16'(y1_not), 16'h0);
      check("rst.w1.out_valid", 16'(ov1), 16'h0);
      check_w8("rst.w8", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      check("rst.w16.y_sel", y16_sel, 16'h0);
      iv1 = 1'b0;
      rst = 1'b0;
      tick();
      check("post_rst.w1.out_valid", 16'(ov1), 16'h0);

      // Truth table, back-to-back valid cycles
      iv1 = 1'b1; op1 = 2'b00;
      for (int i = 0; i < 4; i++) begin
         {a1, b1} = tt_ab[i];
         tick();
         check($sformatf("tt%0d.y_and", i), 16'(y1_and), 16'(tt_and[i]));
         check($sformatf("tt%0d.y_or", i), 16'(y1_or), 16'(tt_or[i]));
         check($sformatf("tt%0d.y_not", i), 16'(y1_not), 16'(tt_not[i]));
         check($sformatf("tt%0d.out_valid", i), 16'(ov1), 16'h1);
      end
      iv1 = 1'b0;

      // Op select on consecutive valid cycles
      a8 = 8'hC5; b8 = 8'h3A; iv8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         op8 = 2'(i);
         tick();
         check($sformatf("opsel%0d.y_sel", i), 16'(y8_sel), 16'(os_exp[i]));
         check($sformatf("opsel%0d.out_valid", i), 16'(ov8), 16'h1);
      end

      // Hold: one accept, then three idle cycles with toggling inputs
      a8 = 8'hF0; b8 = 8'h0F; op8 = 2'b01;
      tick();
      check_w8("hold.cap", 8'h00, 8'hFF, 8'h0F, 8'hFF, 1'b1);
      iv8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a8 = ~a8; b8 = b8 ^ 8'h5A; op8 = op8 + 2'd1;
         tick();
         check_w8($sformatf("hold%0d", i), 8'h00, 8'hFF, 8'h0F, 8'hFF, 1'b0);
      end

      // Async reset pulse between edges
      #2 rst = 1'b1;
      #1;
      check_w8("arst.now", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      check_w8("arst.after", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

      // Reset mid-operation cuts the pending valid pulse
      a8 = 8'h33; b8 = 8'h55; op8 = 2'b11; iv8 = 1'b1;
      tick();
      check_w8("midop.cap", 8'h11, 8'h77, 8'hCC, 8'h66, 1'b1);
      rst = 1'b1;
      #1;
      check_w8("midop.cut", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

      // Reset with in_valid held high, then release between edges
      a8 = 8'h5A; b8 = 8'h66; op8 = 2'b11;
      tick();
      check_w8("rstiv.held", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      rst = 1'b0;
      tick();
      check_w8("rstiv.first", 8'h42, 8'h7E, 8'hA5, 8'h3C, 1'b1);
      iv8 = 1'b0;
      tick();
      check("rstiv.drop.out_valid", 16'(ov8), 16'h0);

      // Randomised check against a behavioural model, WIDTH=16
      m_and = '0; m_or = '0; m_not = '0; m_sel = '0; m_valid = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         a16  = 16'($urandom);
         b16  = 16'($urandom);
         op16 = 2'($urandom_range(3));
         iv16 = 1'($urandom_range(1));
         if (iv16) begin
            m_res = '{a16 & b16, a16 | b16, ~a16, a16 ^ b16};
            m_and = m_res[0];
            m_or  = m_res[1];
            m_not = m_res[2];
            m_sel = m_res[op16];
         end
         m_valid = iv16;
         tick();
         check($sformatf("rnd%0d.out_valid", n), 16'(ov16), 16'(m_valid));
         check($sformatf("rnd%0d.y_and", n), y16_and, m_and);
         check($sformatf("rnd%0d.y_or", n), y16_or, m_or);
         check($sformatf("rnd%0d.y_not", n), y16_not, m_not);
         check($sformatf("rnd%0d.y_sel", n), y16_sel, m_sel);
      end
      iv16 = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

- Registered bitwise logic unit computing AND, OR and NOT(a) of two operand vectors in parallel.
- Also provides one op-selected result.
- Serves as the foundational combinational-gate block of the design, wrapped with a one-cycle registered output stage and a valid strobe so it drops into clocked datapaths.
- Internally built from three gate submodules: `and_gate`, `or_gate` and `not_gate`.

## Interface

Clocking is fixed: one clock; reset is asynchronous and active-high.

Parameters:
- WIDTH, default 1 — operand and result width in bits (must be ≥ 1).

Ports:
- clk, input, 1 — single clock; all state updates on the rising edge.
- rst, input, 1 — asynchronous, active-high reset.
- a, input, WIDTH — operand A.
- b, input, WIDTH — operand B.
- op, input, 2 — select for y_sel:
  - 00 = AND
  - 01 = OR
  - 10 = NOT(a)
  - 11 = XOR
- in_valid, input, 1 — qualifies a, b and op on the current edge.
- y_and, output, WIDTH — registered a & b.
- y_or, output, WIDTH — registered a | b.
- y_not, output, WIDTH — registered ~a.
- y_sel, output, WIDTH — registered result chosen by op.
- out_valid, output, 1 — high for exactly one cycle after each accepted input.

## Operation

- Combinational core:
  - and_gate instances compute a & b.
  - or_gate instances compute a | b.
  - not_gate instances compute ~a.
  - XOR is derived in the wrapper.
  - All results are bitwise and WIDTH bits wide; there is no carry and no cross-bit interaction.
- b has no effect on y_not.
- Capture when in_valid = 1 at a rising clk edge:
  - y_and, y_or, y_not and y_sel load the new results.
  - out_valid is set to 1.
- Behaviour when in_valid = 0 at an edge:
  - y_and, y_or, y_not and y_sel hold their previous values.
  - out_valid is cleared to 0.
- There is no backpressure. A new input may be accepted every cycle, and back-to-back valid inputs produce back-to-back valid outputs.
- op is sampled together with a and b. Changing op without in_valid does not alter y_sel.
- X/Z on the inputs while in_valid = 0 must not propagate into the registers.

## Timing

- Latency: 1 cycle. Inputs presented with in_valid at edge N appear on the outputs with out_valid = 1 after edge N, valid through edge N+1.
- Throughput: 1 result per cycle.
- Reset values, applied asynchronously on rst rising, independent of clk:
  - y_and = 0
  - y_or = 0
  - y_not = 0
  - y_sel = 0
  - out_valid = 0
- While rst is high, all outputs stay at their reset values and in_valid is ignored.
- Reset deassertion: the first capture occurs at the first rising clk edge with rst low and in_valid high.
- Reset mid-operation: a transaction accepted in the cycle before rst asserts is discarded. Its out_valid pulse is cut short immediately.
- No combinational path exists from inputs to outputs. All outputs are register-driven.

## Test plan

- Truth table, WIDTH=1, op=00, in_valid=1 each cycle, with (a,b) = 00, 01, 10, 11. One cycle later each row must show:
  - y_and = 0, 0, 0, 1
  - y_or = 0, 1, 1, 1
  - y_not = 1, 1, 0, 0
- Op select, WIDTH=8, a=8'hC5, b=8'h3A, op stepped 00→01→10→11 on consecutive valid cycles. Required y_sel sequence: 8'h00, 8'hFF, 8'h3A, 8'hFF. Each result appears one cycle after its input, with out_valid = 1 on all four.
- Hold, WIDTH=8: accept a=8'hF0, b=8'h0F, then drop in_valid for 3 cycles while toggling a, b and op.
  - y_and stays 8'h00, y_or stays 8'hFF, y_not stays 8'h0F.
  - out_valid is 1 for one cycle only, then 0.
- Async reset: with outputs non-zero, pulse rst between clk edges. All outputs and out_valid go to 0 before the next edge, and stay 0 until the first valid input after release.
- Reset with in_valid held high: inputs are ignored while rst = 1. The first edge after release captures the current a, b and op.
- Randomised bitwise check, WIDTH=16: 1000 random a, b, op with random in_valid. Every out_valid cycle must match a reference model of &, |, ~a and ^, delayed by one cycle.
